line_collision: RTL and testbench
=================================

Name: line_collision

Overview:
- Downstream consumer of the 640-bit scrolling ground line produced by the line generator.
- Tracks the player (fixed column, can jump) against that line, detects falls into holes, keeps score and runs the game FSM.
- Drives the generator's enable so the line freezes on game over.
- Sits between line generator and VGA renderer/score display.

Parameters:
- LINE_W, 640, width of ground line.
- PLAYER_COL, 100, lowest line bit index under the player.
- PLAYER_W, 16, player footprint width in bits; footprint is line_i[PLAYER_COL +: PLAYER_W].
- JUMP_TICKS, 120, en_i ticks the player stays airborne per jump.
- SCORE_DIV, 80, en_i ticks per score increment.
- SCORE_W, 16, score width.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous, active-high reset.
- en_i  input  1  game tick, one-cycle pulse; all game state advances only on cycles with en_i=1.
- start_i  input  1  start/restart request, level-sampled on en_i ticks.
- jump_i  input  1  jump request, level-sampled on en_i ticks.
- line_i  input  LINE_W  ground line; 1 = ground, 0 = hole.
- gen_en_o  output  1  enable to line generator; combinational en_i AND (state is RUN or JUMP).
- state_o  output  2  FSM state: IDLE=0, RUN=1, JUMP=2, OVER=3.
- airborne_o  output  1  1 while state is JUMP.
- hit_o  output  1  one-cycle pulse, registered, on the tick a collision is detected.
- score_o  output  SCORE_W  current score.

Behaviour:
- Reset (async, reset_i=1): state=IDLE, score=0, jump counter=0, score divider=0, hit_o=0, airborne_o=0. gen_en_o=0 follows from IDLE. Reset mid-game aborts immediately; no partial score is kept.
- All transitions occur on clk_i rising edges with en_i=1. Cycles with en_i=0 hold all state, and hit_o returns to 0.
- hole = any zero bit in line_i[PLAYER_COL +: PLAYER_W] (OR-reduce of the inverted slice).
- IDLE: start_i=1 -> RUN, score=0, divider=0.
- RUN:
  - jump_i=1 -> JUMP, jump counter loaded with JUMP_TICKS-1.
  - else if hole -> OVER, hit_o=1.
  - jump has priority over hole on the same tick.
- JUMP:
  - Counter decrements each tick. Holes are ignored while airborne.
  - When counter=0 -> RUN. Landing is evaluated on the next tick, so landing on a hole causes OVER one tick later.
  - jump_i during JUMP is ignored; there is no double jump.
- OVER: score holds and gen_en_o=0 (line frozen). start_i=1 -> RUN with score=0 and divider=0.
- Score: in RUN and JUMP the divider counts 0..SCORE_DIV-1. On wrap, score increments, saturating at 2^SCORE_W-1. On the transition to OVER, no increment occurs even if the divider wraps on the same tick.
- hit_o latency: one clock after the colliding tick edge (registered). Exactly one pulse per game.
- start_i in RUN/JUMP is ignored.

Optional Feature:
- Macro HIGH_SCORE_EN.
- Defined: adds output hiscore_o [SCORE_W-1:0]. Reset to 0. On entry to OVER, hiscore_o := max(hiscore_o, score). It survives restarts and is cleared only by reset_i.
- Undefined: port and register absent; behaviour otherwise identical.

Decomposition:
- Shared package line_game_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_JUMP, ST_OVER), default LINE_W=640, and the ground/hole bit polarity constant.
- One sub-module, score_counter: divider plus saturating score, with inputs clk_i, reset_i, en_i, clear, run. Instantiated once. The FSM and collision logic stay in the top.

Test Plan:
- Reset with line_i all ones, pulse start_i on a tick -> state_o=1. After 80 ticks score_o=1; after 800 ticks score_o=10. hit_o stays 0.
- RUN, line_i bit 105 = 0 on a tick -> next edge state_o=3, hit_o=1 for one cycle. gen_en_o=0 thereafter. Score frozen.
- RUN, jump_i=1 and bit 100 = 0 on the same tick -> state_o=2, no hit. Hole persists -> after 120 ticks state_o=1, and the next tick gives OVER.
- JUMP with holes under the player for the first 119 ticks, ground restored at landing -> no hit; state_o returns to 1 after exactly 120 ticks.
- OVER, start_i=1 -> state_o=1, score_o=0. With HIGH_SCORE_EN, game 1 scoring 5 then game 2 scoring 3 -> hiscore_o=5.
- Assert reset_i asynchronously mid-JUMP with score 7 -> all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/line_game_pkg.sv
// Shared constants for the ground-line game: FSM state encoding,
// default line width and the ground/hole bit polarity.
package line_game_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_JUMP = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam int DEFAULT_LINE_W = 640;

    // A set bit on the line is solid ground, a clear bit is a hole.
    localparam logic GROUND_BIT = 1'b1;

endpackage

// File: rtl/line_collision_score_counter.sv
// score_counter: tick divider plus saturating score register, advanced
// only on en_i ticks; clear restarts both, run lets the divider count.
module score_counter
    import line_game_pkg::*;
#(
    parameter int SCORE_DIV = 80,
    parameter int SCORE_W   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               clear,
    input  logic               run,
    output logic [SCORE_W-1:0] score_o
);

    localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [SCORE_W-1:0] score_q, score_d;

    always_comb begin
        div_d   = div_q;
        score_d = score_q;
        if (en_i) begin
            if (clear) begin
                div_d   = '0;
                score_d = '0;
            end else if (run) begin
                if (div_q == DIV_W'(SCORE_DIV - 1)) begin
                    div_d = '0;
                    // Score sticks at its maximum rather than wrapping to zero.
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q   <= '0;
            score_q <= '0;
        end else begin
            div_q   <= div_d;
            score_q <= score_d;
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/line_collision.sv
// line_collision: player-vs-ground-line game FSM with jump timer, hole
// detection and scoring. Optional high score register via HIGH_SCORE_EN.
module line_collision
    import line_game_pkg::*;
#(
    parameter int LINE_W     = DEFAULT_LINE_W,
    parameter int PLAYER_COL = 100,
    parameter int PLAYER_W   = 16,
    parameter int JUMP_TICKS = 120,
    parameter int SCORE_DIV  = 80,
    parameter int SCORE_W    = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic               jump_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic               gen_en_o,
    output logic [1:0]         state_o,
    output logic               airborne_o,
    output logic               hit_o,
`ifdef HIGH_SCORE_EN
    output logic [SCORE_W-1:0] hiscore_o,
`endif
    output logic [SCORE_W-1:0] score_o
);

    localparam int JW = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;

    logic [1:0]    state_q, state_d;
    logic [JW-1:0] jump_cnt_q, jump_cnt_d;
    logic          hit_q, hit_d;
    logic          hole;
    logic          clear;
    logic          go_over;
    logic          run;
    logic          line_unused;

    // Only the footprint matters; the rest of the line is for the renderer.
    assign line_unused = ^line_i;
    assign hole = |(line_i[PLAYER_COL +: PLAYER_W] ^ {PLAYER_W{GROUND_BIT}});

    always_comb begin
        state_d    = state_q;
        jump_cnt_d = jump_cnt_q;
        hit_d      = 1'b0;
        clear      = 1'b0;
        go_over    = 1'b0;
        if (en_i) begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_i) begin
                        state_d = ST_RUN;
                        clear   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (jump_i) begin
                        state_d    = ST_JUMP;
                        jump_cnt_d = JW'(JUMP_TICKS - 1);
                    end else if (hole) begin
                        state_d = ST_OVER;
                        hit_d   = 1'b1;
                        go_over = 1'b1;
                    end
                end
                ST_JUMP: begin
                    // Holes are ignored in the air; landing is judged in RUN.
                    if (jump_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        jump_cnt_d = jump_cnt_q - JW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            jump_cnt_q <= '0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            jump_cnt_q <= jump_cnt_d;
            hit_q      <= hit_d;
        end
    end

    // The fatal tick earns no point even if the divider wraps on it.
    assign run = ((state_q == ST_RUN) || (state_q == ST_JUMP)) && !go_over;

    score_counter #(
        .SCORE_DIV (SCORE_DIV),
        .SCORE_W   (SCORE_W)
    ) u_score (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_i),
        .clear   (clear),
        .run     (run),
        .score_o (score_o)
    );

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] hiscore_q, hiscore_d;

    always_comb begin
        hiscore_d = hiscore_q;
        if (go_over && (score_o > hiscore_q)) begin
            hiscore_d = score_o;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hiscore_q <= '0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign hiscore_o = hiscore_q;
`endif

    assign state_o    = state_q;
    assign airborne_o = (state_q == ST_JUMP);
    assign hit_o      = hit_q;
    assign gen_en_o   = en_i && ((state_q == ST_RUN) || (state_q == ST_JUMP));

endmodule

// File: tb/tb_line_collision.sv
// Self-checking bench for line_collision: directed game scenarios plus
// randomized play compared against a tick-level game model.
module tb_line_collision;

    localparam int LINE_W     = 640;
    localparam int PLAYER_COL = 100;
    localparam int PLAYER_W   = 16;
    localparam int JUMP_TICKS = 120;
    localparam int SCORE_DIV  = 80;
    localparam int SCORE_W    = 16;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              en_i = 1'b0;
    logic              start_i = 1'b0;
    logic              jump_i = 1'b0;
    logic [LINE_W-1:0] line_i = '1;
    logic              gen_en_o;
    logic [1:0]        state_o;
    logic              airborne_o;
    logic              hit_o;
    logic [SCORE_W-1:0] score_o;
`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] hiscore_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Game model: mode 0 idle, 1 running, 2 airborne, 3 game over.
    int  m_state;
    int  m_air_left;
    int  m_alive;
    int  m_hi;
    bit  m_hit;
    logic gen_en_seen;
    bit   exp_gen_en;

    always #5 clk = ~clk;

    line_collision dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .en_i       (en_i),
        .start_i    (start_i),
        .jump_i     (jump_i),
        .line_i     (line_i),
        .gen_en_o   (gen_en_o),
        .state_o    (state_o),
        .airborne_o (airborne_o),
        .hit_o      (hit_o),
`ifdef HIGH_SCORE_EN
        .hiscore_o  (hiscore_o),
`endif
        .score_o    (score_o)
    );

    function automatic int exp_score();
        int s;
        s = m_alive / SCORE_DIV;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic bit has_hole(input logic [LINE_W-1:0] l);
        for (int i = 0; i < PLAYER_W; i++) begin
            if (l[PLAYER_COL + i] == 1'b0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [LINE_W-1:0] line_with_hole(input int idx);
        logic [LINE_W-1:0] l;
        l = '1;
        if (idx >= 0) l[idx] = 1'b0;
        return l;
    endfunction

    task automatic model_reset();
        m_state = 0; m_air_left = 0; m_alive = 0; m_hit = 0; m_hi = 0;
    endtask

    task automatic model_step(input bit en, input bit start, input bit jump, input bit hole);
        m_hit = 1'b0;
        if (!en) return;
        case (m_state)
            0, 3: if (start) begin m_state = 1; m_alive = 0; end
            1: begin
                if (jump) begin
                    m_state = 2; m_air_left = JUMP_TICKS; m_alive++;
                end else if (hole) begin
                    if (exp_score() > m_hi) m_hi = exp_score();
                    m_state = 3; m_hit = 1'b1;
                end else begin
                    m_alive++;
                end
            end
            default: begin
                m_alive++;
                m_air_left--;
                if (m_air_left == 0) m_state = 1;
            end
        endcase
    endtask

    // Drives one cycle from a negedge, models it, returns at the next negedge.
    task automatic tick(input bit en, input bit start, input bit jump, input logic [LINE_W-1:0] line);
        en_i = en; start_i = start; jump_i = jump; line_i = line;
        #1;
        gen_en_seen = gen_en_o;
        exp_gen_en  = en && (m_state == 1 || m_state == 2);
        @(posedge clk);
        model_step(en, start, jump, has_hole(line));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        en_i = 1'b0; start_i = 1'b0; jump_i = 1'b0; line_i = '1;
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_i = 1'b1;
        en_i = 1'b1; start_i = 1'b1; jump_i = 1'b0; line_i = '1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (state_o !== 2'd0 || score_o !== '0 || hit_o !== 1'b0 || airborne_o !== 1'b0 || gen_en_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset: state=%0d score=%0d hit=%b air=%b gen_en=%b, required 0/0/0/0/0",
                     state_o, score_o, hit_o, airborne_o, gen_en_o);
        end
        reset_i = 1'b0;
        en_i = 1'b0; start_i = 1'b0;
        model_reset();
    endtask

    task automatic test_score();
        int hits = 0;
        tick(1, 1, 0, '1);
        tests_run++;
        if (state_o !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL start: state=%0d, required 1", state_o);
        end
        for (int t = 1; t <= 800; t++) begin
            tick(1, 0, 0, '1);
            if (hit_o !== 1'b0) hits++;
            if (t == 80) begin
                tests_run++;
                if (score_o !== 16'd1) begin
                    tests_failed++;
                    $display("[TB] FAIL score_80: score=%0d, required 1", score_o);
                end
            end
        end
        tests_run++;
        if (score_o !== 16'd10) begin
            tests_failed++;
            $display("[TB] FAIL score_800: score=%0d, required 10", score_o);
        end
        tests_run++;
        if (hits != 0) begin
            tests_failed++;
            $display("[TB] FAIL no_hit_run: hit cycles=%0d, required 0", hits);
        end
    endtask

    task automatic test_hole();
        tick(1, 0, 0, line_with_hole(105));
        tests_run++;
        if (state_o !== 2'd3 || hit_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hole_hit: state=%0d hit=%b, required 3/1", state_o, hit_o);
        end
        tick(1, 0, 0, '1);
        tests_run++;
        if (hit_o !== 1'b0 || gen_en_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hit_pulse: hit=%b gen_en=%b, required 0/0", hit_o, gen_en_seen);
        end
        for (int t = 0; t < 100; t++) tick(1, 0, 1, '1);
        tests_run++;
        if (score_o !== 16'd10 || state_o !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL over_frozen: score=%0d state=%0d, required 10/3", score_o, state_o);
        end
    endtask

    task automatic test_jump_over_hole();
        tick(1, 1, 0, '1);
        tests_run++;
        if (state_o !== 2'd1 || score_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL restart: state=%0d score=%0d, required 1/0", state_o, score_o);
        end
        tick(1, 0, 1, line_with_hole(100));
        tests_run++;
        if (state_o !== 2'd2 || hit_o !== 1'b0 || airborne_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL jump_priority: state=%0d hit=%b air=%b, required 2/0/1", state_o, hit_o, airborne_o);
        end
        for (int t = 1; t < JUMP_TICKS; t++) tick(1, 0, 1, line_with_hole(100));
        tests_run++;
        if (state_o !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL air_119: state=%0d, required 2", state_o);
        end
        tick(1, 0, 0, line_with_hole(100));
        tests_run++;
        if (state_o !== 2'd1 || hit_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL land_120: state=%0d hit=%b, required 1/0", state_o, hit_o);
        end
        tick(1, 0, 0, line_with_hole(100));
        tests_run++;
        if (state_o !== 2'd3 || hit_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL land_in_hole: state=%0d hit=%b, required 3/1", state_o, hit_o);
        end
    endtask

    task automatic test_clean_landing();
        int bad = 0;
        tick(1, 1, 0, '1);
        tick(1, 0, 1, '1);
        for (int t = 1; t < JUMP_TICKS; t++) begin
            tick(1, 0, 0, line_with_hole(PLAYER_COL + (t % PLAYER_W)));
            if (state_o !== 2'd2 || hit_o !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL airborne_holes: bad cycles=%0d, required 0", bad);
        end
        tick(1, 0, 0, '1);
        tick(1, 0, 0, '1);
        tests_run++;
        if (state_o !== 2'd1 || hit_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL clean_landing: state=%0d hit=%b, required 1/0", state_o, hit_o);
        end
    endtask

    task automatic test_hiscore();
        do_reset();
        tick(1, 1, 0, '1);
        for (int t = 0; t < 5 * SCORE_DIV; t++) tick(1, 0, 0, '1);
        tick(1, 0, 0, line_with_hole(110));
        tests_run++;
        if (score_o !== 16'd5 || state_o !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL game1: score=%0d state=%0d, required 5/3", score_o, state_o);
        end
        tick(1, 1, 0, '1);
        for (int t = 0; t < 3 * SCORE_DIV; t++) tick(1, 0, 0, '1);
        tick(1, 0, 0, line_with_hole(115));
        tests_run++;
        if (score_o !== 16'd3) begin
            tests_failed++;
            $display("[TB] FAIL game2: score=%0d, required 3", score_o);
        end
`ifdef HIGH_SCORE_EN
        tests_run++;
        if (hiscore_o !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL hiscore: hiscore=%0d, required 5", hiscore_o);
        end
`endif
    endtask

    task automatic test_random();
        bit en, st, jp;
        logic [LINE_W-1:0] l;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            en = ($urandom % 8) != 0;
            st = ($urandom % 25) == 0;
            jp = ($urandom % 50) == 0;
            l  = ($urandom % 20 == 0) ? line_with_hole(94 + int'($urandom % 28)) : '1;
            tick(en, st, jp, l);
            tests_run++;
            if (state_o !== 2'(m_state) || airborne_o !== (m_state == 2) || hit_o !== m_hit ||
                score_o !== SCORE_W'(exp_score()) || gen_en_seen !== exp_gen_en) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d]: state=%0d air=%b hit=%b score=%0d gen_en=%b, required %0d/%b/%b/%0d/%b",
                         c, state_o, airborne_o, hit_o, score_o, gen_en_seen,
                         m_state, (m_state == 2), m_hit, exp_score(), exp_gen_en);
            end
`ifdef HIGH_SCORE_EN
            tests_run++;
            if (hiscore_o !== SCORE_W'(m_hi)) begin
                tests_failed++;
                $display("[TB] FAIL random_hiscore[%0d]: hiscore=%0d, required %0d", c, hiscore_o, m_hi);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1, 1, 0, '1);
        for (int t = 0; t < 7 * SCORE_DIV + 5; t++) tick(1, 0, 0, '1);
        tick(1, 0, 1, '1);
        for (int t = 0; t < 10; t++) tick(1, 0, 0, '1);
        tests_run++;
        if (state_o !== 2'd2 || score_o !== 16'd7) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset: state=%0d score=%0d, required 2/7", state_o, score_o);
        end
        en_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        tests_run++;
        if (state_o !== 2'd0 || score_o !== '0 || airborne_o !== 1'b0 || hit_o !== 1'b0 || gen_en_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: state=%0d score=%0d air=%b hit=%b gen_en=%b, required 0/0/0/0/0",
                     state_o, score_o, airborne_o, hit_o, gen_en_o);
        end
`ifdef HIGH_SCORE_EN
        tests_run++;
        if (hiscore_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_hiscore: hiscore=%0d, required 0", hiscore_o);
        end
`endif
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
        tick(0, 0, 0, '1);
    endtask

    initial begin
        model_reset();
        gen_en_seen = 1'b0;
        exp_gen_en  = 1'b0;
        test_reset();
        test_score();
        test_hole();
        test_jump_over_hole();
        test_clean_landing();
        test_hiscore();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
